// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one IM request at a time,
// buffers a word across stalls and drops in-flight fetches on redirect.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        im_req_valid,
   input  logic        im_req_ready,
   output logic [31:0] im_addr,
   input  logic        im_rsp_valid,
   input  logic [31:0] im_rsp_data,
   output logic [31:0] pc_IF,
   output logic [31:0] instr_IF,
   output logic        isinstruct_IF
);

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_DROP,
      S_HOLD
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] pend_pc;
   logic [31:0] hold_pc;
   logic [31:0] hold_data;
   logic        handshake;

   assign im_req_valid = (state == S_REQ) & ~redirect_valid;
   assign im_addr      = pc;
   assign handshake    = im_req_valid & im_req_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_REQ;
         pc            <= RESET_PC;
         pend_pc       <= '0;
         hold_pc       <= '0;
         hold_data     <= '0;
         pc_IF         <= '0;
         instr_IF      <= NOP_INSTR;
         isinstruct_IF <= 1'b0;
      end else if (redirect_valid) begin
         // Redirect wins over stall and any same-cycle response.
         pc            <= redirect_pc;
         pc_IF         <= '0;
         instr_IF      <= NOP_INSTR;
         isinstruct_IF <= 1'b0;
         unique case (state)
            S_WAIT, S_DROP: state <= im_rsp_valid ? S_REQ : S_DROP;
            S_REQ, S_HOLD:  state <= S_REQ;
         endcase
      end else begin
         if (!stall) begin
            pc_IF         <= '0;
            instr_IF      <= NOP_INSTR;
            isinstruct_IF <= 1'b0;
         end
         unique case (state)
            S_REQ: begin
               if (handshake) begin
                  pend_pc <= pc;
                  pc      <= pc + 32'd4;
                  state   <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (im_rsp_valid && !stall) begin
                  pc_IF         <= pend_pc;
                  instr_IF      <= im_rsp_data;
                  isinstruct_IF <= 1'b1;
                  state         <= S_REQ;
               end else if (im_rsp_valid) begin
                  hold_pc   <= pend_pc;
                  hold_data <= im_rsp_data;
                  state     <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (!stall) begin
                  pc_IF         <= hold_pc;
                  instr_IF      <= hold_data;
                  isinstruct_IF <= 1'b1;
                  state         <= S_REQ;
               end
            end
            S_DROP: begin
               if (im_rsp_valid) state <= S_REQ;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed testbench for if_fetch_stage.
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_if_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        im_req_valid;
   logic        im_req_ready;
   logic [31:0] im_addr;
   logic        im_rsp_valid;
   logic [31:0] im_rsp_data;
   logic [31:0] pc_IF;
   logic [31:0] instr_IF;
   logic        isinstruct_IF;

   int checks;
   int errors;

   if_fetch_stage dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .im_req_valid  (im_req_valid),
      .im_req_ready  (im_req_ready),
      .im_addr       (im_addr),
      .im_rsp_valid  (im_rsp_valid),
      .im_rsp_data   (im_rsp_data),
      .pc_IF         (pc_IF),
      .instr_IF      (instr_IF),
      .isinstruct_IF (isinstruct_IF)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept one request and return data the following cycle.
   task automatic deliver(input logic [31:0] data);
      im_req_ready = 1'b1;
      tick();
      im_req_ready = 1'b0;
      im_rsp_valid = 1'b1;
      im_rsp_data  = data;
      tick();
      im_rsp_valid = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      stall = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      im_req_ready = 1'b0;
      im_rsp_valid = 1'b0;
      im_rsp_data = '0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if (pc_IF !== 32'h0) begin
         errors++;
         $display("FAIL reset_pc_IF got %h exp %h", pc_IF, 32'h0);
      end
      checks++;
      if (instr_IF !== NOP) begin
         errors++;
         $display("FAIL reset_instr got %h exp %h", instr_IF, NOP);
      end
      checks++;
      if (isinstruct_IF !== 1'b0) begin
         errors++;
         $display("FAIL reset_isinstr got %b exp 0", isinstruct_IF);
      end
      checks++;
      if (im_req_valid !== 1'b1 || im_addr !== 32'h0) begin
         errors++;
         $display("FAIL reset_req got v=%b a=%h exp v=1 a=0",
                  im_req_valid, im_addr);
      end
   endtask

   task automatic test_fetch();
      for (int k = 0; k < 3; k++) begin
         logic [31:0] exp_pc;
         logic [31:0] exp_d;
         exp_pc = 32'(4 * k);
         exp_d  = 32'h0000_1000 + 32'(k);
         im_req_ready = 1'b1;
         #1;
         checks++;
         if (im_req_valid !== 1'b1 || im_addr !== exp_pc) begin
            errors++;
            $display("FAIL fetch_addr got v=%b a=%h exp v=1 a=%h",
                     im_req_valid, im_addr, exp_pc);
         end
         tick();
         im_req_ready = 1'b0;
         im_rsp_valid = 1'b1;
         im_rsp_data  = exp_d;
         #1;
         checks++;
         if (im_req_valid !== 1'b0 || isinstruct_IF !== 1'b0) begin
            errors++;
            $display("FAIL fetch_wait got v=%b i=%b exp v=0 i=0",
                     im_req_valid, isinstruct_IF);
         end
         tick();
         im_rsp_valid = 1'b0;
         checks++;
         if (pc_IF !== exp_pc || instr_IF !== exp_d ||
             isinstruct_IF !== 1'b1) begin
            errors++;
            $display("FAIL fetch_out got pc=%h in=%h i=%b exp pc=%h in=%h i=1",
                     pc_IF, instr_IF, isinstruct_IF, exp_pc, exp_d);
         end
      end
   endtask

   task automatic test_stall();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      deliver(32'h0000_0A00);
      deliver(32'h0000_0B04);
      // Accept pc 8 while stalled, so the real pc 4 output stays frozen.
      stall = 1'b1;
      im_req_ready = 1'b1;
      tick();
      im_req_ready = 1'b0;
      im_rsp_valid = 1'b1;
      im_rsp_data  = 32'h00A0_0093;
      tick();
      im_rsp_valid = 1'b0;
      #1;
      checks++;
      if (pc_IF !== 32'h4 || instr_IF !== 32'h0000_0B04 ||
          isinstruct_IF !== 1'b1) begin
         errors++;
         $display("FAIL stall_frozen got pc=%h in=%h i=%b exp pc=4 in=00000b04 i=1",
                  pc_IF, instr_IF, isinstruct_IF);
      end
      checks++;
      if (im_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL stall_hold_noreq got %b exp 0", im_req_valid);
      end
      tick();
      checks++;
      if (pc_IF !== 32'h4 || im_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL stall_hold2 got pc=%h v=%b exp pc=4 v=0",
                  pc_IF, im_req_valid);
      end
      stall = 1'b0;
      tick();
      checks++;
      if (pc_IF !== 32'h8 || instr_IF !== 32'h00A0_0093 ||
          isinstruct_IF !== 1'b1) begin
         errors++;
         $display("FAIL stall_release got pc=%h in=%h i=%b exp pc=8 in=00a00093 i=1",
                  pc_IF, instr_IF, isinstruct_IF);
      end
      checks++;
      if (im_req_valid !== 1'b1 || im_addr !== 32'hC) begin
         errors++;
         $display("FAIL stall_next_req got v=%b a=%h exp v=1 a=c",
                  im_req_valid, im_addr);
      end
   endtask

   task automatic test_redirect();
      im_req_ready = 1'b1;
      tick();
      im_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc = 32'h100;
      tick();
      redirect_valid = 1'b0;
      #1;
      checks++;
      if (pc_IF !== 32'h0 || instr_IF !== NOP || isinstruct_IF !== 1'b0) begin
         errors++;
         $display("FAIL redir_bubble got pc=%h in=%h i=%b exp bubble",
                  pc_IF, instr_IF, isinstruct_IF);
      end
      checks++;
      if (im_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL redir_drop_noreq got %b exp 0", im_req_valid);
      end
      im_rsp_valid = 1'b1;
      im_rsp_data = 32'hDEAD_BEEF;
      tick();
      im_rsp_valid = 1'b0;
      #1;
      checks++;
      if (isinstruct_IF !== 1'b0 || instr_IF !== NOP) begin
         errors++;
         $display("FAIL redir_late_rsp got i=%b in=%h exp i=0 in=%h",
                  isinstruct_IF, instr_IF, NOP);
      end
      checks++;
      if (im_req_valid !== 1'b1 || im_addr !== 32'h100) begin
         errors++;
         $display("FAIL redir_addr got v=%b a=%h exp v=1 a=100",
                  im_req_valid, im_addr);
      end
   endtask

   task automatic test_redirect_rsp();
      deliver(32'h0000_0111);
      stall = 1'b1;
      im_req_ready = 1'b1;
      tick();
      im_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc = 32'h200;
      im_rsp_valid = 1'b1;
      im_rsp_data = 32'h0000_BEEF;
      tick();
      redirect_valid = 1'b0;
      im_rsp_valid = 1'b0;
      #1;
      checks++;
      if (pc_IF !== 32'h0 || instr_IF !== NOP || isinstruct_IF !== 1'b0) begin
         errors++;
         $display("FAIL redir_rsp_bubble got pc=%h in=%h i=%b exp bubble",
                  pc_IF, instr_IF, isinstruct_IF);
      end
      checks++;
      if (im_req_valid !== 1'b1 || im_addr !== 32'h200) begin
         errors++;
         $display("FAIL redir_rsp_addr got v=%b a=%h exp v=1 a=200",
                  im_req_valid, im_addr);
      end
      stall = 1'b0;
      // Redirect in REQ suppresses the request even with ready high.
      redirect_valid = 1'b1;
      redirect_pc = 32'h300;
      im_req_ready = 1'b1;
      #1;
      checks++;
      if (im_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL redir_req_suppress got %b exp 0", im_req_valid);
      end
      tick();
      redirect_valid = 1'b0;
      im_req_ready = 1'b0;
      #1;
      checks++;
      if (im_req_valid !== 1'b1 || im_addr !== 32'h300) begin
         errors++;
         $display("FAIL redir_req_addr got v=%b a=%h exp v=1 a=300",
                  im_req_valid, im_addr);
      end
   endtask

   task automatic test_backpressure();
      im_req_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (im_req_valid !== 1'b1 || im_addr !== 32'h300 ||
             isinstruct_IF !== 1'b0) begin
            errors++;
            $display("FAIL bp_cycle%0d got v=%b a=%h i=%b exp v=1 a=300 i=0",
                     k, im_req_valid, im_addr, isinstruct_IF);
         end
      end
   endtask

   task automatic test_wrap_reset();
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      deliver(32'h0000_0F0F);
      checks++;
      if (pc_IF !== 32'hFFFF_FFFC || instr_IF !== 32'h0000_0F0F ||
          isinstruct_IF !== 1'b1) begin
         errors++;
         $display("FAIL wrap_out got pc=%h in=%h i=%b exp pc=fffffffc in=00000f0f i=1",
                  pc_IF, instr_IF, isinstruct_IF);
      end
      checks++;
      if (im_addr !== 32'h0) begin
         errors++;
         $display("FAIL wrap_pc got %h exp 0", im_addr);
      end
      im_req_ready = 1'b1;
      tick();
      im_req_ready = 1'b0;
      checks++;
      if (im_addr !== 32'h4 || im_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL wrap_wait got a=%h v=%b exp a=4 v=0",
                  im_addr, im_req_valid);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      im_rsp_valid = 1'b1;
      im_rsp_data = 32'h1234_5678;
      #1;
      checks++;
      if (im_req_valid !== 1'b1 || im_addr !== 32'h0) begin
         errors++;
         $display("FAIL rst_wait_pc got v=%b a=%h exp v=1 a=0",
                  im_req_valid, im_addr);
      end
      tick();
      im_rsp_valid = 1'b0;
      #1;
      checks++;
      if (isinstruct_IF !== 1'b0 || instr_IF !== NOP ||
          im_req_valid !== 1'b1 || im_addr !== 32'h0) begin
         errors++;
         $display("FAIL rst_late_rsp got i=%b in=%h v=%b a=%h exp i=0 nop v=1 a=0",
                  isinstruct_IF, instr_IF, im_req_valid, im_addr);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_fetch();
      test_stall();
      test_redirect();
      test_redirect_rsp();
      test_backpressure();
      test_wrap_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
